// File: rtl/smmha_tile_fsm_if.sv
// ============================================================================
// Module   : smmha_tile_fsm_if
// Brief    : Streamer/engine handshake bundle of the tiling controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface smmha_tile_fsm_if #(
    parameter int NB_SRC = 2,
    parameter int LEN_W  = 16
);
    logic [NB_SRC-1:0]    src_ready_start_i;
    logic                 sink_ready_start_i;
    logic [LEN_W-1:0]     engine_cnt_i;
    logic [NB_SRC-1:0]    src_req_start_o;
    logic                 sink_req_start_o;
    logic [NB_SRC*32-1:0] src_addr_o;
    logic [31:0]          sink_addr_o;
    logic [LEN_W-1:0]     trans_size_o;
    logic                 engine_start_o;
    logic                 engine_clear_o;

    modport master (
        input  src_ready_start_i, sink_ready_start_i, engine_cnt_i,
        output src_req_start_o, sink_req_start_o, src_addr_o, sink_addr_o,
               trans_size_o, engine_start_o, engine_clear_o
    );

    modport slave (
        output src_ready_start_i, sink_ready_start_i, engine_cnt_i,
        input  src_req_start_o, sink_req_start_o, src_addr_o, sink_addr_o,
               trans_size_o, engine_start_o, engine_clear_o
    );
endinterface

`default_nettype wire

// File: rtl/smmha_tile_fsm.sv
// ============================================================================
// Module   : smmha_tile_fsm
// Brief    : Tile sequencer: starts source/sink streamers and the engine once
//            per tile, walking addresses by a fixed stride. Optional COMPUTE
//            watchdog enabled by SMMHA_TILE_FSM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module smmha_tile_fsm #(
    parameter int NB_SRC  = 2,
    parameter int LEN_W   = 16,
    parameter int TILES_W = 8,
    parameter int TIMEOUT = 65535
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic                 clear_i,
    input  wire logic                 start_i,
    input  wire logic [NB_SRC*32-1:0] src_base_i,
    input  wire logic [31:0]          sink_base_i,
    input  wire logic [31:0]          tile_stride_i,
    input  wire logic [LEN_W-1:0]     len_i,
    input  wire logic [TILES_W-1:0]   n_tiles_i,
    output logic [TILES_W-1:0]        tile_idx_o,
    output logic                      busy_o,
    output logic                      evt_o,
    output logic                      done_o,
    output logic                      err_o,
    smmha_tile_fsm_if.master          bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_TERM    = 3'd5;

    logic [2:0]           r_state;
    logic [TILES_W-1:0]   r_tile_idx;
    logic [TILES_W-1:0]   r_n_tiles;
    logic [LEN_W-1:0]     r_len;
    logic [31:0]          r_stride;
    logic [NB_SRC*32-1:0] r_src_addr;
    logic [31:0]          r_sink_addr;
    logic                 r_req;
    logic                 r_estart;
    logic                 r_evt;
    logic                 r_done;

    logic w_all_ready;
    logic w_match;
    logic w_last;
    logic w_timeout;

    assign w_all_ready = (&bus.src_ready_start_i) & bus.sink_ready_start_i;
    assign w_match     = (bus.engine_cnt_i == r_len);
    assign w_last      = (r_tile_idx == (r_n_tiles - TILES_W'(1)));

`ifdef SMMHA_TILE_FSM_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // Counter restarts on every COMPUTE entry, so the limit is per tile.
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
        end else if (clear_i || (r_state != S_COMPUTE)) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (clear_i) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_err <= 1'b0;
        end else if ((r_state == S_COMPUTE) && !w_match && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign err_o            = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_tile_idx  <= '0;
            r_n_tiles   <= '0;
            r_len       <= '0;
            r_stride    <= '0;
            r_src_addr  <= '0;
            r_sink_addr <= '0;
            r_req       <= 1'b0;
            r_estart    <= 1'b0;
            r_evt       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_req    <= 1'b0;
            r_estart <= 1'b0;
            r_evt    <= 1'b0;
            r_done   <= 1'b0;
            if (clear_i) begin
                r_state     <= S_IDLE;
                r_tile_idx  <= '0;
                r_src_addr  <= '0;
                r_sink_addr <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_len       <= len_i;
                            r_n_tiles   <= n_tiles_i;
                            r_stride    <= tile_stride_i;
                            r_src_addr  <= src_base_i;
                            r_sink_addr <= sink_base_i;
                            r_tile_idx  <= '0;
                            // Empty jobs skip straight to the completion handshake.
                            if ((len_i == '0) || (n_tiles_i == '0)) begin
                                r_state <= S_TERM;
                            end else begin
                                r_state <= S_START;
                            end
                        end
                    end
                    S_START, S_WAIT: begin
                        if (w_all_ready) begin
                            r_req    <= 1'b1;
                            r_estart <= 1'b1;
                            r_state  <= S_COMPUTE;
                        end else begin
                            r_state  <= S_WAIT;
                        end
                    end
                    S_COMPUTE: begin
                        if (w_match) begin
                            r_evt   <= 1'b1;
                            r_state <= w_last ? S_TERM : S_NEXT;
                        end else if (w_timeout) begin
                            r_state <= S_TERM;
                        end
                    end
                    S_NEXT: begin
                        r_tile_idx  <= r_tile_idx + TILES_W'(1);
                        r_sink_addr <= r_sink_addr + r_stride;
                        for (int k = 0; k < NB_SRC; k++) begin
                            r_src_addr[32*k +: 32] <= r_src_addr[32*k +: 32] + r_stride;
                        end
                        r_state <= S_WAIT;
                    end
                    S_TERM: begin
                        if (w_all_ready) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.src_req_start_o  = {NB_SRC{r_req}};
    assign bus.sink_req_start_o = r_req;
    assign bus.src_addr_o       = r_src_addr;
    assign bus.sink_addr_o      = r_sink_addr;
    assign bus.trans_size_o     = r_len;
    assign bus.engine_start_o   = r_estart;
    assign bus.engine_clear_o   = (r_state == S_IDLE) || (r_state == S_NEXT);

    assign tile_idx_o = r_tile_idx;
    assign busy_o     = (r_state != S_IDLE);
    assign evt_o      = r_evt;
    assign done_o     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_smmha_tile_fsm.sv
// ============================================================================
// Module   : tb_smmha_tile_fsm
// Brief    : Directed job table plus hand sequences for stall, clear, reset
//            and stuck-engine cases of smmha_tile_fsm (default build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_smmha_tile_fsm;

    typedef struct packed {
        logic [31:0]      b0;
        logic [31:0]      b1;
        logic [31:0]      bs;
        logic [31:0]      stride;
        logic [15:0]      len;
        logic [7:0]       nt;
        logic [7:0]       exp_req;
        logic [2:0][31:0] e0;
        logic [2:0][31:0] e1;
        logic [2:0][31:0] es;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [63:0] src_base_i;
    logic [31:0] sink_base_i;
    logic [31:0] tile_stride_i;
    logic [15:0] len_i;
    logic [7:0]  n_tiles_i;
    logic [7:0]  tile_idx_o;
    logic        busy_o;
    logic        evt_o;
    logic        done_o;
    logic        err_o;

    smmha_tile_fsm_if #(.NB_SRC(2), .LEN_W(16)) u_if ();

    smmha_tile_fsm #(
        .NB_SRC(2), .LEN_W(16), .TILES_W(8), .TIMEOUT(8)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .src_base_i    (src_base_i),
        .sink_base_i   (sink_base_i),
        .tile_stride_i (tile_stride_i),
        .len_i         (len_i),
        .n_tiles_i     (n_tiles_i),
        .tile_idx_o    (tile_idx_o),
        .busy_o        (busy_o),
        .evt_o         (evt_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .bus           (u_if.master)
    );

    always #5 clk = ~clk;

    job_t        jobs[5];
    int          errors = 0;
    int          checks = 0;
    int          n_req, n_evt, n_done, n_est;
    int          cur;
    bit          chk_addr;
    bit          stuck;
    logic [15:0] eng_len;
    logic [15:0] eng;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge and advance the engine model.
    task automatic tick();
        @(negedge clk);
        if (u_if.src_req_start_o[0]) begin
            if (chk_addr && n_req < 3) begin
                check("src0_addr", {32'h0, u_if.src_addr_o[31:0]}, {32'h0, jobs[cur].e0[n_req]});
                check("src1_addr", {32'h0, u_if.src_addr_o[63:32]}, {32'h0, jobs[cur].e1[n_req]});
                check("sink_addr", {32'h0, u_if.sink_addr_o}, {32'h0, jobs[cur].es[n_req]});
                check("trans_size", {48'h0, u_if.trans_size_o}, {48'h0, jobs[cur].len});
            end
            check("req_align", {60'h0, u_if.src_req_start_o, u_if.sink_req_start_o,
                                u_if.engine_start_o}, 64'hF);
            n_req++;
        end
        if (evt_o) n_evt++;
        if (done_o) n_done++;
        if (u_if.engine_start_o) n_est++;
        if (u_if.engine_start_o || u_if.engine_clear_o) eng = '0;
        else if (!stuck && eng < eng_len) eng = eng + 16'd1;
        u_if.engine_cnt_i = eng;
    endtask

    task automatic start_job(input int idx);
        n_req = 0; n_evt = 0; n_done = 0; n_est = 0;
        cur = idx;
        chk_addr = 1'b1;
        eng_len = jobs[idx].len;
        src_base_i    = {jobs[idx].b1, jobs[idx].b0};
        sink_base_i   = jobs[idx].bs;
        tile_stride_i = jobs[idx].stride;
        len_i         = jobs[idx].len;
        n_tiles_i     = jobs[idx].nt;
        start_i       = 1'b1;
        tick();
        start_i       = 1'b0;
        // Latched values must survive input changes while the job runs.
        src_base_i    = 64'hDEAD_BEEF_0BAD_F00D;
        sink_base_i   = 32'h5555_0000;
        tile_stride_i = 32'h4;
        len_i         = 16'd7;
        n_tiles_i     = 8'd9;
    endtask

    task automatic run_until_done(input bit poke);
        int extra;
        extra = -1;
        for (int i = 0; i < 200 && extra != 0; i++) begin
            start_i = poke && (i == 2);
            tick();
            start_i = 1'b0;
            if (extra > 0) extra--;
            else if (extra < 0 && n_done > 0) extra = 5;
        end
    endtask

    initial begin
        jobs[0] = '{b0: 32'h100, b1: 32'h200, bs: 32'h300, stride: 32'h40, len: 16'd4,
                    nt: 8'd3, exp_req: 8'd3,
                    e0: {32'h180, 32'h140, 32'h100}, e1: {32'h280, 32'h240, 32'h200},
                    es: {32'h380, 32'h340, 32'h300}};
        jobs[1] = '{b0: 32'h100, b1: 32'h200, bs: 32'h300, stride: 32'h40, len: 16'd4,
                    nt: 8'd0, exp_req: 8'd0, e0: '0, e1: '0, es: '0};
        jobs[2] = '{b0: 32'h100, b1: 32'h200, bs: 32'h300, stride: 32'h40, len: 16'd0,
                    nt: 8'd2, exp_req: 8'd0, e0: '0, e1: '0, es: '0};
        jobs[3] = '{b0: 32'hFFFF_FFF0, b1: 32'h1000, bs: 32'hFFFF_FFE0, stride: 32'h20,
                    len: 16'd2, nt: 8'd2, exp_req: 8'd2,
                    e0: {32'h0, 32'h0000_0010, 32'hFFFF_FFF0},
                    e1: {32'h0, 32'h1020, 32'h1000},
                    es: {32'h0, 32'h0000_0000, 32'hFFFF_FFE0}};
        jobs[4] = '{b0: 32'hA, b1: 32'hB, bs: 32'hC, stride: 32'h0, len: 16'd1,
                    nt: 8'd1, exp_req: 8'd1,
                    e0: {32'h0, 32'h0, 32'hA}, e1: {32'h0, 32'h0, 32'hB},
                    es: {32'h0, 32'h0, 32'hC}};

        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        src_base_i = '0; sink_base_i = '0; tile_stride_i = '0; len_i = '0; n_tiles_i = '0;
        u_if.src_ready_start_i = 2'b11; u_if.sink_ready_start_i = 1'b1;
        eng = '0; eng_len = '0; stuck = 1'b0; chk_addr = 1'b0; cur = 0;
        u_if.engine_cnt_i = '0;
        n_req = 0; n_evt = 0; n_done = 0; n_est = 0;

        #12;
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_tile", {56'h0, tile_idx_o}, 64'h0);
        check("rst_addr", {u_if.src_addr_o}, 64'h0);
        check("rst_sink", {32'h0, u_if.sink_addr_o}, 64'h0);
        check("rst_size", {48'h0, u_if.trans_size_o}, 64'h0);
        check("rst_pulses", {58'h0, u_if.src_req_start_o, u_if.sink_req_start_o,
                             u_if.engine_start_o, evt_o, done_o}, 64'h0);
        check("rst_err", {63'h0, err_o}, 64'h0);
        check("rst_eclr", {63'h0, u_if.engine_clear_o}, 64'h1);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        for (int j = 0; j < 5; j++) begin
            start_job(j);
            run_until_done(j == 0);
            check($sformatf("job%0d_req", j), 64'(n_req), 64'(jobs[j].exp_req));
            check($sformatf("job%0d_evt", j), 64'(n_evt), 64'(jobs[j].exp_req));
            check($sformatf("job%0d_estart", j), 64'(n_est), 64'(jobs[j].exp_req));
            check($sformatf("job%0d_done", j), 64'(n_done), 64'h1);
            check($sformatf("job%0d_idle", j), {62'h0, busy_o, err_o}, 64'h0);
        end

        // Source 1 not ready: job must park in WAIT with no requests.
        u_if.src_ready_start_i = 2'b01;
        start_job(4);
        for (int i = 0; i < 10; i++) tick();
        check("stall_req", 64'(n_req), 64'h0);
        check("stall_state", {62'h0, busy_o, u_if.engine_clear_o}, 64'h2);
        u_if.src_ready_start_i = 2'b11;
        run_until_done(1'b0);
        check("stall_req_after", 64'(n_req), 64'h1);
        check("stall_done", 64'(n_done), 64'h1);

        // Soft clear in the second tile's COMPUTE.
        start_job(0);
        for (int i = 0; i < 100 && n_req < 2; i++) tick();
        check("clr_tile_before", {56'h0, tile_idx_o}, 64'h1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_busy", {63'h0, busy_o}, 64'h0);
        check("clr_tile", {56'h0, tile_idx_o}, 64'h0);
        check("clr_addr", u_if.src_addr_o, 64'h0);
        check("clr_sink", {32'h0, u_if.sink_addr_o}, 64'h0);
        check("clr_eclr", {63'h0, u_if.engine_clear_o}, 64'h1);
        for (int i = 0; i < 20; i++) tick();
        check("clr_no_done", 64'(n_done), 64'h0);
        check("clr_no_req", 64'(n_req), 64'h2);

        // Stuck engine without the watchdog: COMPUTE forever, no error.
        stuck = 1'b1;
        start_job(4);
        for (int i = 0; i < 40; i++) tick();
        check("stuck_evt", 64'(n_evt), 64'h0);
        check("stuck_done", 64'(n_done), 64'h0);
        check("stuck_state", {61'h0, busy_o, u_if.engine_clear_o, err_o}, 64'h4);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        stuck = 1'b0;
        check("stuck_recover", {63'h0, busy_o}, 64'h0);

        // Asynchronous reset mid-job abandons it silently.
        start_job(0);
        for (int i = 0; i < 3; i++) tick();
        #2 rst_ni = 1'b0;
        #1;
        check("amid_busy", {63'h0, busy_o}, 64'h0);
        check("amid_tile_addr", {u_if.src_addr_o[31:0], 24'h0, tile_idx_o}, 64'h0);
        check("amid_eclr", {63'h0, u_if.engine_clear_o}, 64'h1);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("amid_no_done", 64'(n_done), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
